// File: rtl/rob_pkg.sv
// Shared types for the multi-port reorder buffer: entry layout and id-width helper.
// Entry field widths follow ROB_WORD_SIZE / ROB_REG_IDX_W; top-level WORD_SIZE / REG_IDX_W must match.
package rob_pkg;

    localparam int unsigned ROB_WORD_SIZE = 32;
    localparam int unsigned ROB_REG_IDX_W = 5;

    typedef struct packed {
        logic                     valid;
        logic                     ready;
        logic                     is_store;
        logic                     exception;
        logic [ROB_REG_IDX_W-1:0] rd;
        logic [ROB_WORD_SIZE-1:0] pc;
        logic [ROB_WORD_SIZE-1:0] value;
        logic [ROB_WORD_SIZE-1:0] v_addr;
    } rob_entry_t;

    function automatic int unsigned rob_id_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rob_wb_merge.sv
// Priority select of NUM_WB writeback ports targeting one entry id; lowest port index wins.
module rob_wb_merge #(
    parameter int unsigned NUM_WB    = 3,
    parameter int unsigned ID_W      = 3,
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic [NUM_WB-1:0]           wb_valid,
    input  logic [NUM_WB*ID_W-1:0]      wb_id,
    input  logic [NUM_WB*WORD_SIZE-1:0] wb_data,
    input  logic [NUM_WB-1:0]           wb_exception,
    input  logic [NUM_WB*WORD_SIZE-1:0] wb_v_addr,
    input  logic [ID_W-1:0]             target_id,
    output logic                        hit,
    output logic [WORD_SIZE-1:0]        data,
    output logic                        exception,
    output logic [WORD_SIZE-1:0]        v_addr
);

    // Scan from the highest port down so the lowest matching port is applied last.
    always_comb begin
        hit       = 1'b0;
        data      = '0;
        exception = 1'b0;
        v_addr    = '0;
        for (int p = int'(NUM_WB) - 1; p >= 0; p--) begin
            if (wb_valid[p] && (wb_id[p*ID_W +: ID_W] == target_id)) begin
                hit       = 1'b1;
                data      = wb_data[p*WORD_SIZE +: WORD_SIZE];
                exception = wb_exception[p];
                v_addr    = wb_v_addr[p*WORD_SIZE +: WORD_SIZE];
            end
        end
    end

endmodule

// File: rtl/rob_multiport.sv
// Circular in-order reorder buffer with NUM_WB writeback ports and precise exception flush.
// Define ROB_WB_FORWARD_EN to forward same-cycle writebacks onto the bypass read ports.
module rob_multiport
    import rob_pkg::*;
#(
    parameter int unsigned WORD_SIZE = ROB_WORD_SIZE,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned NUM_WB    = 3,
    parameter int unsigned REG_IDX_W = ROB_REG_IDX_W,
    parameter int unsigned ID_W      = rob_id_width(DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_req,
    input  logic                        alloc_is_store,
    input  logic [REG_IDX_W-1:0]        alloc_rd,
    input  logic [WORD_SIZE-1:0]        alloc_pc,
    input  logic                        alloc_exception,
    output logic [ID_W-1:0]             alloc_id,
    output logic                        full,
    output logic                        empty,
    input  logic [NUM_WB-1:0]           wb_valid,
    input  logic [NUM_WB*ID_W-1:0]      wb_id,
    input  logic [NUM_WB*WORD_SIZE-1:0] wb_data,
    input  logic [NUM_WB-1:0]           wb_exception,
    input  logic [NUM_WB*WORD_SIZE-1:0] wb_v_addr,
    input  logic [ID_W-1:0]             rs1_id,
    input  logic [ID_W-1:0]             rs2_id,
    output logic [WORD_SIZE-1:0]        bypass_s1,
    output logic [WORD_SIZE-1:0]        bypass_s2,
    output logic                        bypass_s1_valid,
    output logic                        bypass_s2_valid,
    output logic                        commit,
    output logic [REG_IDX_W-1:0]        commit_rd,
    output logic [WORD_SIZE-1:0]        commit_value,
    output logic [ID_W-1:0]             commit_id,
    output logic                        sb_store_permission,
    output logic [ID_W-1:0]             sb_rob_id,
    output logic                        exception,
    output logic [WORD_SIZE-1:0]        ex_pc,
    output logic [WORD_SIZE-1:0]        ex_v_addr
);

    typedef logic [ID_W:0] rob_ptr_t;

    rob_entry_t entries_q [DEPTH];
    rob_entry_t entries_d [DEPTH];
    rob_ptr_t   head_q, head_d, tail_q, tail_d;

    logic [ID_W-1:0] head_id, tail_id;
    rob_entry_t      head_entry;
    logic            retire, flush;

    logic [DEPTH-1:0] wb_hit;
    logic [DEPTH-1:0] wb_sel_exc;
    logic [WORD_SIZE-1:0] wb_sel_data [DEPTH];
    logic [WORD_SIZE-1:0] wb_sel_va   [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_merge
        rob_wb_merge #(
            .NUM_WB    (NUM_WB),
            .ID_W      (ID_W),
            .WORD_SIZE (WORD_SIZE)
        ) u_merge (
            .wb_valid     (wb_valid),
            .wb_id        (wb_id),
            .wb_data      (wb_data),
            .wb_exception (wb_exception),
            .wb_v_addr    (wb_v_addr),
            .target_id    (ID_W'(i)),
            .hit          (wb_hit[i]),
            .data         (wb_sel_data[i]),
            .exception    (wb_sel_exc[i]),
            .v_addr       (wb_sel_va[i])
        );
    end

    assign head_id    = head_q[ID_W-1:0];
    assign tail_id    = tail_q[ID_W-1:0];
    assign head_entry = entries_q[head_id];

    assign full     = (head_q[ID_W] != tail_q[ID_W]) && (head_id == tail_id);
    assign empty    = (head_q == tail_q);
    assign alloc_id = tail_id;

    // Retirement outputs depend only on registered head state.
    always_comb begin
        retire              = head_entry.valid && head_entry.ready && !head_entry.exception;
        flush               = head_entry.valid && head_entry.ready && head_entry.exception;
        commit              = retire && !head_entry.is_store;
        sb_store_permission = retire && head_entry.is_store;
        exception           = flush;
        commit_rd           = head_entry.rd;
        commit_value        = head_entry.value;
        commit_id           = head_id;
        sb_rob_id           = head_id;
        ex_pc               = head_entry.pc;
        ex_v_addr           = head_entry.v_addr;
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (wb_hit[i] && entries_q[i].valid) begin
                entries_d[i].value     = wb_sel_data[i];
                entries_d[i].ready     = 1'b1;
                entries_d[i].exception = wb_sel_exc[i];
                entries_d[i].v_addr    = wb_sel_va[i];
            end
        end
        if (retire) begin
            entries_d[head_id].valid = 1'b0;
            head_d                   = head_q + rob_ptr_t'(1);
        end
        if (alloc_req && !full) begin
            entries_d[tail_id] = '{valid:     1'b1,
                                   ready:     alloc_exception,
                                   is_store:  alloc_is_store,
                                   exception: alloc_exception,
                                   rd:        alloc_rd,
                                   pc:        alloc_pc,
                                   value:     '0,
                                   v_addr:    '0};
            tail_d = tail_q + rob_ptr_t'(1);
        end
        // A faulting head discards everything, including this cycle's allocation.
        if (flush) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_d[i].valid = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            entries_q <= entries_d;
        end
    end

`ifdef ROB_WB_FORWARD_EN
    logic                 fwd1_hit, fwd2_hit, fwd1_exc, fwd2_exc;
    logic [WORD_SIZE-1:0] fwd1_data, fwd2_data, fwd1_va, fwd2_va;
    logic                 unused_fwd_va;

    rob_wb_merge #(
        .NUM_WB    (NUM_WB),
        .ID_W      (ID_W),
        .WORD_SIZE (WORD_SIZE)
    ) u_fwd1 (
        .wb_valid     (wb_valid),
        .wb_id        (wb_id),
        .wb_data      (wb_data),
        .wb_exception (wb_exception),
        .wb_v_addr    (wb_v_addr),
        .target_id    (rs1_id),
        .hit          (fwd1_hit),
        .data         (fwd1_data),
        .exception    (fwd1_exc),
        .v_addr       (fwd1_va)
    );

    rob_wb_merge #(
        .NUM_WB    (NUM_WB),
        .ID_W      (ID_W),
        .WORD_SIZE (WORD_SIZE)
    ) u_fwd2 (
        .wb_valid     (wb_valid),
        .wb_id        (wb_id),
        .wb_data      (wb_data),
        .wb_exception (wb_exception),
        .wb_v_addr    (wb_v_addr),
        .target_id    (rs2_id),
        .hit          (fwd2_hit),
        .data         (fwd2_data),
        .exception    (fwd2_exc),
        .v_addr       (fwd2_va)
    );

    assign unused_fwd_va = ^{fwd1_va, fwd2_va};

    always_comb begin
        bypass_s1       = entries_q[rs1_id].value;
        bypass_s1_valid = entries_q[rs1_id].valid && entries_q[rs1_id].ready &&
                          !entries_q[rs1_id].exception;
        bypass_s2       = entries_q[rs2_id].value;
        bypass_s2_valid = entries_q[rs2_id].valid && entries_q[rs2_id].ready &&
                          !entries_q[rs2_id].exception;
        // Only live entries accept writeback, so only they may forward.
        if (fwd1_hit && entries_q[rs1_id].valid) begin
            bypass_s1       = fwd1_data;
            bypass_s1_valid = !fwd1_exc;
        end
        if (fwd2_hit && entries_q[rs2_id].valid) begin
            bypass_s2       = fwd2_data;
            bypass_s2_valid = !fwd2_exc;
        end
    end
`else
    always_comb begin
        bypass_s1       = entries_q[rs1_id].value;
        bypass_s1_valid = entries_q[rs1_id].valid && entries_q[rs1_id].ready &&
                          !entries_q[rs1_id].exception;
        bypass_s2       = entries_q[rs2_id].value;
        bypass_s2_valid = entries_q[rs2_id].valid && entries_q[rs2_id].ready &&
                          !entries_q[rs2_id].exception;
    end
`endif

endmodule

// File: tb/tb_rob_multiport.sv
// Bench for rob_multiport: queue-based reference model checked every cycle plus directed literals.
module tb_rob_multiport;

    localparam int W  = 32;
    localparam int D  = 8;
    localparam int NW = 3;
    localparam int RW = 5;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            alloc_req, alloc_is_store, alloc_exception;
    logic [RW-1:0]   alloc_rd;
    logic [W-1:0]    alloc_pc;
    logic [IW-1:0]   alloc_id;
    logic            full, empty;
    logic [NW-1:0]   wb_valid, wb_exception;
    logic [NW*IW-1:0] wb_id;
    logic [NW*W-1:0] wb_data, wb_v_addr;
    logic [IW-1:0]   rs1_id, rs2_id;
    logic [W-1:0]    bypass_s1, bypass_s2;
    logic            bypass_s1_valid, bypass_s2_valid;
    logic            commit, sb_store_permission, exception;
    logic [RW-1:0]   commit_rd;
    logic [W-1:0]    commit_value, ex_pc, ex_v_addr;
    logic [IW-1:0]   commit_id, sb_rob_id;

    always #5 clk = ~clk;

    rob_multiport #(
        .WORD_SIZE (W),
        .DEPTH     (D),
        .NUM_WB    (NW),
        .REG_IDX_W (RW)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .alloc_req           (alloc_req),
        .alloc_is_store      (alloc_is_store),
        .alloc_rd            (alloc_rd),
        .alloc_pc            (alloc_pc),
        .alloc_exception     (alloc_exception),
        .alloc_id            (alloc_id),
        .full                (full),
        .empty               (empty),
        .wb_valid            (wb_valid),
        .wb_id               (wb_id),
        .wb_data             (wb_data),
        .wb_exception        (wb_exception),
        .wb_v_addr           (wb_v_addr),
        .rs1_id              (rs1_id),
        .rs2_id              (rs2_id),
        .bypass_s1           (bypass_s1),
        .bypass_s2           (bypass_s2),
        .bypass_s1_valid     (bypass_s1_valid),
        .bypass_s2_valid     (bypass_s2_valid),
        .commit              (commit),
        .commit_rd           (commit_rd),
        .commit_value        (commit_value),
        .commit_id           (commit_id),
        .sb_store_permission (sb_store_permission),
        .sb_rob_id           (sb_rob_id),
        .exception           (exception),
        .ex_pc               (ex_pc),
        .ex_v_addr           (ex_v_addr)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: program-order queue of live ids plus per-id contents.
    int           q[$];
    bit           m_live[D], m_ready[D], m_exc[D], m_store[D], m_va_known[D];
    logic [RW-1:0] m_rd[D];
    logic [W-1:0] m_pc[D], m_val[D], m_va[D];
    int           next_id;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        q.delete();
        for (int i = 0; i < D; i++) begin
            m_live[i] = 0; m_ready[i] = 0; m_exc[i] = 0; m_store[i] = 0; m_va_known[i] = 0;
        end
        next_id = 0;
    endfunction

    function automatic void exp_bypass(input logic [IW-1:0] id, output bit v,
                                       output logic [W-1:0] val);
        v   = m_live[id] && m_ready[id] && !m_exc[id];
        val = m_val[id];
`ifdef ROB_WB_FORWARD_EN
        for (int p = 0; p < NW; p++) begin
            if (wb_valid[p] && wb_id[p*IW +: IW] == id && m_live[id]) begin
                v   = !wb_exception[p];
                val = wb_data[p*W +: W];
                break;
            end
        end
`endif
    endfunction

    always @(negedge clk) begin
        bit            e_commit, e_sb, e_exc, bv;
        int            h;
        logic [W-1:0]  bval;
        if (chk_en) begin
            e_commit = 0; e_sb = 0; e_exc = 0; h = 0;
            if (q.size() > 0) begin
                h = q[0];
                if (m_ready[h]) begin
                    e_exc    = m_exc[h];
                    e_commit = !m_exc[h] && !m_store[h];
                    e_sb     = !m_exc[h] && m_store[h];
                end
            end
            chk("empty", empty, q.size() == 0);
            chk("full", full, q.size() == D);
            chk("alloc_id", alloc_id, next_id);
            chk("commit", commit, e_commit);
            chk("sb_perm", sb_store_permission, e_sb);
            chk("exception", exception, e_exc);
            if (e_commit) begin
                chk("commit_id", commit_id, h);
                chk("commit_rd", commit_rd, m_rd[h]);
                chk("commit_value", commit_value, m_val[h]);
            end
            if (e_sb) chk("sb_rob_id", sb_rob_id, h);
            if (e_exc) begin
                chk("ex_pc", ex_pc, m_pc[h]);
                if (m_va_known[h]) chk("ex_v_addr", ex_v_addr, m_va[h]);
            end
            exp_bypass(rs1_id, bv, bval);
            chk("bypass_s1_valid", bypass_s1_valid, bv);
            if (bv) chk("bypass_s1", bypass_s1, bval);
            exp_bypass(rs2_id, bv, bval);
            chk("bypass_s2_valid", bypass_s2_valid, bv);
            if (bv) chk("bypass_s2", bypass_s2, bval);
        end
    end

    task automatic idle_inputs();
        alloc_req = 0; alloc_is_store = 0; alloc_exception = 0; alloc_rd = '0; alloc_pc = '0;
        wb_valid = '0; wb_exception = '0; wb_id = '0; wb_data = '0; wb_v_addr = '0;
    endtask

    // Advance one clock and apply the same edge to the model.
    task automatic tick();
        bit do_ret, do_flush;
        bit taken[D];
        int h, sz, id;
        @(posedge clk);
        if (rst) begin
            model_clear();
            chk_en = 1'b1;
        end else begin
            do_ret = 0; do_flush = 0; h = 0; sz = q.size();
            if (sz > 0) begin
                h = q[0];
                if (m_ready[h]) begin
                    if (m_exc[h]) do_flush = 1; else do_ret = 1;
                end
            end
            if (do_flush) begin
                model_clear();
            end else begin
                for (int p = 0; p < NW; p++) begin
                    id = int'(wb_id[p*IW +: IW]);
                    if (wb_valid[p] && m_live[id] && !taken[id]) begin
                        taken[id]      = 1;
                        m_val[id]      = wb_data[p*W +: W];
                        m_ready[id]    = 1;
                        m_exc[id]      = wb_exception[p];
                        m_va[id]       = wb_v_addr[p*W +: W];
                        m_va_known[id] = 1;
                    end
                end
                if (do_ret) begin
                    m_live[h] = 0;
                    void'(q.pop_front());
                end
                if (alloc_req && sz < D) begin
                    q.push_back(next_id);
                    m_live[next_id]     = 1;
                    m_ready[next_id]    = alloc_exception;
                    m_exc[next_id]      = alloc_exception;
                    m_store[next_id]    = alloc_is_store;
                    m_rd[next_id]       = alloc_rd;
                    m_pc[next_id]       = alloc_pc;
                    m_va_known[next_id] = 0;
                    next_id             = (next_id + 1) % D;
                end
            end
        end
        #1;
        idle_inputs();
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic alloc(input int rd, input logic [W-1:0] pc, input bit st = 0, input bit ex = 0);
        alloc_req = 1; alloc_rd = RW'(rd); alloc_pc = pc; alloc_is_store = st; alloc_exception = ex;
    endtask

    task automatic wb(input int p, input int id, input logic [W-1:0] d, input bit ex = 0,
                      input logic [W-1:0] va = '0);
        wb_valid[p]          = 1'b1;
        wb_id[p*IW +: IW]    = IW'(id);
        wb_data[p*W +: W]    = d;
        wb_exception[p]      = ex;
        wb_v_addr[p*W +: W]  = va;
    endtask

    task automatic do_reset();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rs1_id = '0;
        rs2_id = '0;
        do_reset();
        settle();
        chk("rst_full", full, 0);
        chk("rst_empty", empty, 1);
        chk("rst_commit", commit, 0);
        chk("rst_sb", sb_store_permission, 0);
        chk("rst_exception", exception, 0);
        chk("rst_alloc_id", alloc_id, 0);

        // Fill to capacity, then try a ninth allocation.
        for (int i = 0; i < D; i++) begin
            alloc(i + 1, 32'h100 + 4 * i);
            tick();
        end
        settle();
        chk("fill_full", full, 1);
        chk("fill_alloc_id", alloc_id, 0);
        alloc(9, 32'h200);
        tick();
        settle();
        chk("ninth_full", full, 1);
        chk("ninth_alloc_id", alloc_id, 0);
        // Retiring while full must not admit a same-cycle allocation.
        wb(0, 0, 32'h1000);
        tick();
        alloc(9, 32'h204);
        settle();
        chk("full_ret_commit", commit, 1);
        chk("full_ret_commit_id", commit_id, 0);
        tick();
        settle();
        chk("full_ret_not_full", full, 0);
        chk("full_ret_alloc_id", alloc_id, 0);
        wb(0, 1, 32'h1001); wb(1, 2, 32'h1002); wb(2, 3, 32'h1003);
        tick();
        wb(0, 4, 32'h1004); wb(1, 5, 32'h1005); wb(2, 6, 32'h1006);
        tick();
        wb(0, 7, 32'h1007);
        tick();
        for (int k = 0; k < 12; k++) begin
            settle();
            if (empty) break;
            tick();
        end
        chk("drain_empty", empty, 1);

        // Out-of-order writeback, in-order commit.
        do_reset();
        alloc(5, 32'h200); tick();
        alloc(6, 32'h204); tick();
        wb(0, 1, 32'h11);
        settle();
        chk("ooo_no_commit0", commit, 0);
        tick();
        wb(1, 0, 32'h10);
        settle();
        chk("ooo_no_commit1", commit, 0);
        tick();
        settle();
        chk("ooo_commit_a", commit, 1);
        chk("ooo_commit_id_a", commit_id, 0);
        chk("ooo_commit_val_a", commit_value, 32'h10);
        chk("ooo_commit_rd_a", commit_rd, 5);
        tick();
        settle();
        chk("ooo_commit_b", commit, 1);
        chk("ooo_commit_id_b", commit_id, 1);
        chk("ooo_commit_val_b", commit_value, 32'h11);
        tick();
        settle();
        chk("ooo_empty", empty, 1);

        // Store at head gets store-buffer permission, not commit.
        alloc(0, 32'h208, 1); tick();
        wb(2, 2, 32'h77); tick();
        settle();
        chk("store_sb", sb_store_permission, 1);
        chk("store_sb_id", sb_rob_id, 2);
        chk("store_commit", commit, 0);
        tick();

        // Two ports hit the same id: port 0 wins.
        alloc(7, 32'h20c); tick();
        rs1_id = 3;
        wb(0, 3, 32'hAAAA); wb(2, 3, 32'h5555);
        tick();
        settle();
        chk("prio_commit", commit, 1);
        chk("prio_value", commit_value, 32'hAAAA);
        chk("prio_bypass", bypass_s1, 32'hAAAA);
        chk("prio_bypass_valid", bypass_s1_valid, 1);
        tick();

        // Writeback fault at head flushes everything, including a same-cycle alloc.
        alloc(8, 32'h300); tick();
        alloc(9, 32'h304); tick();
        wb(1, 4, 32'h0, 1, 32'h1004);
        tick();
        alloc(10, 32'h308);
        settle();
        chk("exc_flag", exception, 1);
        chk("exc_v_addr", ex_v_addr, 32'h1004);
        chk("exc_pc", ex_pc, 32'h300);
        chk("exc_commit", commit, 0);
        tick();
        settle();
        chk("exc_empty", empty, 1);
        chk("exc_alloc_id", alloc_id, 0);

        // Bypass timing with and without same-cycle forwarding.
        alloc(1, 32'h500); tick();
        alloc(2, 32'h504); tick();
        alloc(3, 32'h508); tick();
        rs1_id = 2;
        rs2_id = 1;
        wb(1, 2, 32'h42);
        settle();
`ifdef ROB_WB_FORWARD_EN
        chk("fwd_same_valid", bypass_s1_valid, 1);
        chk("fwd_same_value", bypass_s1, 32'h42);
`else
        chk("nofwd_same_valid", bypass_s1_valid, 0);
`endif
        tick();
        settle();
        chk("byp_next_valid", bypass_s1_valid, 1);
        chk("byp_next_value", bypass_s1, 32'h42);

        // Decode-time fault: entry born ready and faulted.
        wb(0, 0, 32'h1); wb(1, 1, 32'h2);
        alloc(11, 32'h400, 0, 1);
        tick();
        for (int k = 0; k < 10; k++) begin
            settle();
            if (exception) break;
            tick();
        end
        chk("itlb_exc", exception, 1);
        chk("itlb_pc", ex_pc, 32'h400);
        tick();
        settle();
        chk("itlb_empty", empty, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
